// File: rtl/busm_arb.sv
// Four-requester round-robin bus arbiter with a bounded hold time and a registered shared bus.
// Optional bus-busy counter output is built when BUSM_ARB_CNT_EN is defined.
module busm_arb #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] iB,
    output logic [3:0]  gnt,
    output logic [3:0]  oB,
    output logic        vld
`ifdef BUSM_ARB_CNT_EN
    ,
    output logic [7:0]  busy_cnt
`endif
);

    typedef enum logic [0:0] {StIdle, StOwn} state_e;

    localparam logic [3:0] HoldTop = 4'(HOLD_MAX - 1);

    state_e      state_q;
    logic [1:0]  owner_q;
    logic [1:0]  ptr_q;
    logic [3:0]  hold_q;
    logic [3:0]  gnt_q;
    logic [3:0]  ob_q;
    logic        vld_q;
`ifdef BUSM_ARB_CNT_EN
    logic [7:0]  cnt_q;
`endif

    logic [3:0]  owner_oh;
    logic [3:0]  others;
    logic [1:0]  idle_pick;
    logic [1:0]  next_pick;
    logic        hold_top;
    logic        owner_req;

    // First asserted bit of r, scanning start, start+1, ... mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] pick;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] idx;
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        owner_oh  = 4'b0001 << owner_q;
        others    = req & ~owner_oh;
        owner_req = req[owner_q];
        idle_pick = rr_pick(req, ptr_q);
        next_pick = rr_pick(others, owner_q + 2'd1);
        hold_top  = (hold_q == HoldTop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            hold_q  <= 4'd0;
            gnt_q   <= 4'd0;
            ob_q    <= 4'h0;
            vld_q   <= 1'b0;
`ifdef BUSM_ARB_CNT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    vld_q <= 1'b0;
                    if (|req) begin
                        state_q <= StOwn;
                        owner_q <= idle_pick;
                        gnt_q   <= 4'b0001 << idle_pick;
                        ptr_q   <= idle_pick + 2'd1;
                        hold_q  <= 4'd0;
                    end
                end
                StOwn: begin
                    if (!owner_req && (others == 4'd0)) begin
                        // Release with nobody waiting: no final bus load.
                        state_q <= StIdle;
                        gnt_q   <= 4'd0;
                        vld_q   <= 1'b0;
                        hold_q  <= 4'd0;
                    end else begin
                        // Bus sees the current owner's slice even on a handover edge.
                        ob_q  <= iB[{owner_q, 2'b00} +: 4];
                        vld_q <= 1'b1;
`ifdef BUSM_ARB_CNT_EN
                        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
`endif
                        if (!owner_req || (hold_top && (others != 4'd0))) begin
                            owner_q <= next_pick;
                            gnt_q   <= 4'b0001 << next_pick;
                            ptr_q   <= next_pick + 2'd1;
                            hold_q  <= 4'd0;
                        end else if (!hold_top) begin
                            hold_q  <= hold_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        assert ($onehot0(gnt_q));
    end

    assign gnt = gnt_q;
    assign oB  = ob_q;
    assign vld = vld_q;
`ifdef BUSM_ARB_CNT_EN
    assign busy_cnt = cnt_q;
`endif

endmodule
